pic_ack_sequencer: RTL and testbench
====================================

# pic_ack_sequencer

CPU-side responder of the 8259-style PIC. Takes the masked request vector from the interrupt request register, resolves priority against the in-service register (ISR) it owns, raises `int_o`, and runs the two-pulse INTA acknowledge handshake. It sets the ISR bit, issues the one-hot clear back to the request register, drives the interrupt vector on the data bus, and retires in-service levels on EOI.

## Interface
- `NUM_IR`, 8: interrupt lines; fixed at 8, level width 3.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `irr` in 8: masked pending requests; bit 0 is highest priority.
- `vector_base` in 5: T7..T3 of the vector (from ICW2).
- `inta_n` in 1: CPU acknowledge strobe, active low, sampled on `clk`.
- `eoi_i` in 1: one-cycle EOI command pulse.
- `eoi_specific_i` in 1: qualifies `eoi_i`. 1 means specific EOI, 0 means non-specific.
- `eoi_level_i` in 3: level cleared by a specific EOI.
- `aeoi_i` in 1: auto-EOI mode select; present only with `PIC_AEOI_EN`.
- `int_o` out 1: interrupt request to CPU.
- `freeze_o` out 1: tells the request register to hold its sample during the acknowledge.
- `clear_irr_o` out 8: one-cycle one-hot clear of the acknowledged request.
- `isr_o` out 8: in-service register.
- `data_o` out 8: vector byte.
- `data_oe_o` out 1: data bus drive enable.

## Operation
- Eligible request: lowest-numbered set bit of `irr` whose level is numerically lower than the lowest set bit of `isr_o` (fully nested mode). If ISR is empty, any set bit is eligible.
- `int_o` is registered. It is 1 while an eligible request exists in IDLE. It drops on the first INTA fall.
- `inta_n` is registered once into `inta_q`. A fall is `inta_q==1 && inta_n==0`; a rise is the inverse.
- FSM states: IDLE, ACK1, WAIT2, ACK2.
  - IDLE -> ACK1 on a fall. This happens even if `int_o` is 0 (stray acknowledge).
    - Latch the eligible level `lvl`, set `isr_o[lvl]`, pulse `clear_irr_o[lvl]`, assert `freeze_o`.
    - If nothing is eligible, set `lvl=7`, mark the acknowledge spurious, and change neither ISR nor the IRR clear.
  - ACK1 -> WAIT2 on a rise.
  - WAIT2 -> ACK2 on a fall. `data_o={vector_base,lvl}` and `data_oe_o=1` hold while in ACK2.
  - ACK2 -> IDLE on a rise. `data_oe_o` drops, `freeze_o` drops, and the auto-EOI action (Configuration) applies.
- Non-specific EOI clears the lowest set ISR bit. Specific EOI clears `isr_o[eoi_level_i]`. EOI with an empty ISR has no effect.
- Simultaneous ISR set (ACK1 entry) and EOI in the same cycle:
  - EOI target is computed from the pre-update ISR.
  - A clear of the bit being set loses; the set wins.
- `data_o` holds its last value when `data_oe_o=0`.

## Timing
- Reset values: state IDLE; `int_o`, `freeze_o`, `data_oe_o` are 0; `isr_o`, `clear_irr_o`, `data_o` are 8'h00.
- Reset is asynchronous. Asserting `rst_n` mid-handshake returns to IDLE and zeroes ISR immediately. A pending INTA resumes only from a fresh fall.
- Latency from a registered fall to the visible outputs is 1 cycle: `clear_irr_o`, `isr_o` update, `freeze_o`, and `int_o` low.
- Latency from the second fall to valid `data_o`/`data_oe_o` is 1 cycle.
- `clear_irr_o` is high for exactly 1 cycle per non-spurious acknowledge.
- `int_o` re-evaluates in the cycle after return to IDLE.
- `irr` changes during ACK1..ACK2 do not alter `lvl`.

## Configuration
- `PIC_AEOI_EN` defined:
  - `aeoi_i` port exists.
  - With `aeoi_i=1`, the ACK2->IDLE transition clears `isr_o[lvl]` for non-spurious acknowledges, in the same cycle as `data_oe_o` falls.
- `PIC_AEOI_EN` undefined: no `aeoi_i` port, and ISR bits clear only via EOI.

## Structure
- `pic_pkg`:
  - state enum (IDLE/ACK1/WAIT2/ACK2)
  - `NUM_IR=8`, `LVL_W=3`
  - `SPURIOUS_LVL=3'd7`
  - a function returning the lowest set bit index plus a valid flag
- Sub-module `pic_priority_resolver`: combinational; takes `irr` and `isr`, returns eligible level and valid. It is reused by the EOI-lowest-bit logic.

## Test plan
- `irr=8'h24`, ISR empty, two INTA pulses, `vector_base=5'h11`:
  - `int_o=1`
  - `clear_irr_o=8'h04` for 1 cycle; `isr_o=8'h04`
  - vector `8'h8A` on the second pulse with `data_oe_o=1`
  - IDLE after
- ISR=8'h04, `irr=8'h08` -> `int_o` stays 0. Then `irr=8'h02` -> `int_o=1` and ack sets `isr_o=8'h06`.
- `isr_o=8'h06`, non-specific EOI -> `8'h04`. Then specific EOI level 2 -> `8'h00`.
- INTA with `irr=0`: vector `{vector_base,3'd7}`, `isr_o` unchanged, no `clear_irr_o` pulse.
- Reset asserted during WAIT2: all outputs are reset values immediately. The next INTA pair behaves as the first test.
- `PIC_AEOI_EN`, `aeoi_i=1`, `irr=8'h01`: after the second rise, `isr_o` returns to 8'h00 in the same cycle `data_oe_o` drops.

Source files
------------

// File: rtl/pic_ack_sequencer_pkg.sv
// pic_pkg: shared types and helpers for the PIC acknowledge sequencer.
//   ack_state_e  : INTA handshake states (IDLE/ACK1/WAIT2/ACK2)
//   NUM_IR/LVL_W : 8 interrupt lines, 3-bit level
//   SPURIOUS_LVL : level reported when an acknowledge finds nothing eligible
//   lowest_set() : lowest set bit index plus valid flag (bit 0 = highest priority)
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned LVL_W  = 3;

  typedef logic [NUM_IR-1:0] vec_t;
  typedef logic [LVL_W-1:0]  lvl_t;

  localparam lvl_t SPURIOUS_LVL = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } ack_state_e;

  typedef struct packed {
    logic valid;
    lvl_t lvl;
  } lowest_t;

  function automatic lowest_t lowest_set(input vec_t v);
    lowest_t r;
    r.valid = 1'b0;
    r.lvl   = '0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      if (!r.valid && v[lvl_t'(i)]) begin
        r.valid = 1'b1;
        r.lvl   = lvl_t'(i);
      end
    end
    return r;
  endfunction

  function automatic vec_t lvl_onehot(input lvl_t lvl);
    return vec_t'(1) << lvl;
  endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// pic_ack_sequencer_if: CPU-side acknowledge bus of the PIC.
//   inta_n    : CPU acknowledge strobe, active low (driven by CPU)
//   int_o     : interrupt request to the CPU
//   data_o    : interrupt vector byte
//   data_oe_o : data bus drive enable
// Modports: master = CPU side, slave = PIC (pic_ack_sequencer).
interface pic_ack_sequencer_if;
  logic       inta_n;
  logic       int_o;
  logic [7:0] data_o;
  logic       data_oe_o;

  modport master (
    output inta_n,
    input  int_o,
    input  data_o,
    input  data_oe_o
  );

  modport slave (
    input  inta_n,
    output int_o,
    output data_o,
    output data_oe_o
  );
endinterface

// File: rtl/pic_ack_sequencer_priority_resolver.sv
// pic_priority_resolver: combinational fully-nested priority resolution.
//   irr     in  8 : pending request vector (bit 0 highest priority)
//   isr     in  8 : in-service vector
//   lvl_o   out 3 : lowest set request level
//   valid_o out 1 : that level outranks every in-service level
// Driving isr with zero turns this into a plain lowest-set-bit finder.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  vec_t irr,
  input  vec_t isr,
  output lvl_t lvl_o,
  output logic valid_o
);

  lowest_t req;
  lowest_t srv;

  always_comb begin
    req     = lowest_set(irr);
    srv     = lowest_set(isr);
    lvl_o   = req.lvl;
    valid_o = req.valid && (!srv.valid || (req.lvl < srv.lvl));
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// pic_ack_sequencer: CPU-side responder of an 8259-style PIC.
// Resolves priority of irr against the owned ISR, raises int_o, runs the
// two-pulse INTA handshake, presents {vector_base, lvl} during the second
// pulse and retires in-service levels on EOI.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   irr               : masked pending requests (bit 0 highest priority)
//   vector_base       : vector bits T7..T3
//   eoi_i             : one-cycle EOI pulse
//   eoi_specific_i    : 1 = specific EOI of eoi_level_i, 0 = non-specific
//   eoi_level_i       : level retired by a specific EOI
//   aeoi_i            : auto-EOI select (only with PIC_AEOI_EN)
//   freeze_o          : hold request register sample during acknowledge
//   clear_irr_o       : one-cycle one-hot clear of the acknowledged request
//   isr_o             : in-service register
//   cpu               : inta_n / int_o / data_o / data_oe_o bus
// Build option: define PIC_AEOI_EN to add aeoi_i and auto-EOI on ACK2 exit.
module pic_ack_sequencer
  import pic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  vec_t                 irr,
  input  logic [4:0]           vector_base,
  input  logic                 eoi_i,
  input  logic                 eoi_specific_i,
  input  lvl_t                 eoi_level_i,
`ifdef PIC_AEOI_EN
  input  logic                 aeoi_i,
`endif
  output logic                 freeze_o,
  output vec_t                 clear_irr_o,
  output vec_t                 isr_o,
  pic_ack_sequencer_if.slave   cpu
);

  ack_state_e state_q, state_d;
  logic       inta_q, inta_d;
  logic       int_q, int_d;
  logic       freeze_q, freeze_d;
  vec_t       clear_q, clear_d;
  vec_t       isr_q, isr_d;
  logic [7:0] data_q, data_d;
  logic       data_oe_q, data_oe_d;
  lvl_t       lvl_q, lvl_d;
  logic       spurious_q, spurious_d;

  lvl_t elig_lvl;
  logic elig_valid;
  lvl_t isr_low_lvl;
  logic isr_low_valid;

  logic inta_fall;
  logic inta_rise;
  vec_t set_mask;
  vec_t eoi_mask;
  vec_t aeoi_mask;

  pic_priority_resolver u_req_resolver (
    .irr     (irr),
    .isr     (isr_q),
    .lvl_o   (elig_lvl),
    .valid_o (elig_valid)
  );

  // Same resolver with an empty ISR yields the lowest in-service level.
  pic_priority_resolver u_eoi_resolver (
    .irr     (isr_q),
    .isr     ('0),
    .lvl_o   (isr_low_lvl),
    .valid_o (isr_low_valid)
  );

  assign inta_fall = inta_q && !cpu.inta_n;
  assign inta_rise = !inta_q && cpu.inta_n;

  always_comb begin
    state_d    = state_q;
    inta_d     = cpu.inta_n;
    int_d      = 1'b0;
    freeze_d   = freeze_q;
    clear_d    = '0;
    data_d     = data_q;
    data_oe_d  = data_oe_q;
    lvl_d      = lvl_q;
    spurious_d = spurious_q;
    set_mask   = '0;
    aeoi_mask  = '0;

    unique case (state_q)
      IDLE: begin
        int_d = elig_valid && !inta_fall;
        if (inta_fall) begin
          state_d  = ACK1;
          freeze_d = 1'b1;
          if (elig_valid) begin
            lvl_d      = elig_lvl;
            spurious_d = 1'b0;
            clear_d    = lvl_onehot(elig_lvl);
            set_mask   = lvl_onehot(elig_lvl);
          end else begin
            lvl_d      = SPURIOUS_LVL;
            spurious_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_rise) state_d = WAIT2;
      end
      WAIT2: begin
        if (inta_fall) begin
          state_d   = ACK2;
          data_oe_d = 1'b1;
          data_d    = {vector_base, lvl_q};
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          freeze_d  = 1'b0;
`ifdef PIC_AEOI_EN
          if (aeoi_i && !spurious_q) aeoi_mask = lvl_onehot(lvl_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // EOI target comes from the pre-update ISR; OR-ing the set mask last
    // lets a same-cycle acknowledge win over a clear of that bit.
    eoi_mask = '0;
    if (eoi_i) begin
      if (eoi_specific_i)     eoi_mask = lvl_onehot(eoi_level_i);
      else if (isr_low_valid) eoi_mask = lvl_onehot(isr_low_lvl);
    end
    isr_d = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
  end

  // inta_q resets low so an INTA held low across reset is not seen as a
  // fall; only a fresh high-to-low edge starts a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inta_q     <= 1'b0;
      int_q      <= 1'b0;
      freeze_q   <= 1'b0;
      clear_q    <= '0;
      isr_q      <= '0;
      data_q     <= '0;
      data_oe_q  <= 1'b0;
      lvl_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inta_q     <= inta_d;
      int_q      <= int_d;
      freeze_q   <= freeze_d;
      clear_q    <= clear_d;
      isr_q      <= isr_d;
      data_q     <= data_d;
      data_oe_q  <= data_oe_d;
      lvl_q      <= lvl_d;
      spurious_q <= spurious_d;
    end
  end

  assign freeze_o      = freeze_q;
  assign clear_irr_o   = clear_q;
  assign isr_o         = isr_q;
  assign cpu.int_o     = int_q;
  assign cpu.data_o    = data_q;
  assign cpu.data_oe_o = data_oe_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
module tb_pic_ack_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] irr;
  logic [4:0] vector_base;
  logic       eoi_i;
  logic       eoi_specific_i;
  logic [2:0] eoi_level_i;
  logic       aeoi_i;
  logic       freeze_o;
  logic [7:0] clear_irr_o;
  logic [7:0] isr_o;

  pic_ack_sequencer_if cpu_bus ();

  pic_ack_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irr            (irr),
    .vector_base    (vector_base),
    .eoi_i          (eoi_i),
    .eoi_specific_i (eoi_specific_i),
    .eoi_level_i    (eoi_level_i),
`ifdef PIC_AEOI_EN
    .aeoi_i         (aeoi_i),
`endif
    .freeze_o       (freeze_o),
    .clear_irr_o    (clear_irr_o),
    .isr_o          (isr_o),
    .cpu            (cpu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [7:0] m_irr;
  logic [7:0] m_isr;
  logic       m_aeoi;

  logic [7:0] exp_clear[$];
  logic [7:0] exp_data[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest-priority pending request that outranks everything in service, or -1.
  function automatic int eligible(input logic [7:0] r, input logic [7:0] s);
    int top_service = 8;
    for (int i = 7; i >= 0; i--) if (s[i]) top_service = i;
    for (int i = 0; i < 8; i++) if (r[i]) return (i < top_service) ? i : -1;
    return -1;
  endfunction

  function automatic logic [7:0] retire_highest(input logic [7:0] s);
    logic [7:0] r = s;
    for (int i = 0; i < 8; i++) if (r[i]) begin r[i] = 1'b0; return r; end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT-presented outputs against the scoreboard queues.
  logic [7:0] prev_clear;
  logic       prev_oe;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clear = '0;
      prev_oe    = 1'b0;
    end else begin
      if (clear_irr_o != 8'h00) begin
        if (prev_clear != 8'h00) check("clear_width", prev_clear, 8'h00);
        if (exp_clear.size() == 0) check("clear_unexpected", clear_irr_o, 8'h00);
        else check("clear_irr", clear_irr_o, exp_clear.pop_front());
      end
      if (cpu_bus.data_oe_o && !prev_oe) begin
        if (exp_data.size() == 0) check("data_unexpected", {7'd0, cpu_bus.data_oe_o}, 8'h00);
        else check("vector", cpu_bus.data_o, exp_data.pop_front());
      end
      prev_clear = clear_irr_o;
      prev_oe    = cpu_bus.data_oe_o;
    end
  end

  task automatic set_irr(input logic [7:0] v);
    irr   = v;
    m_irr = v;
    step();
    step();
    check("int_level", {7'd0, cpu_bus.int_o}, (eligible(m_irr, m_isr) >= 0) ? 8'h01 : 8'h00);
  endtask

  // mode: 0 = non-specific EOI, 1 = specific EOI of lvl
  task automatic do_eoi(input int mode, input logic [2:0] lvl);
    eoi_i          = 1'b1;
    eoi_specific_i = (mode == 1);
    eoi_level_i    = lvl;
    if (mode == 1) m_isr[lvl] = 1'b0;
    else           m_isr = retire_highest(m_isr);
    step();
    eoi_i = 1'b0;
    check("isr_eoi", isr_o, m_isr);
  endtask

  // eoi_mode: 0 none, 1 non-specific, 2 specific -- issued on the same edge as the first fall.
  task automatic do_ack(input bit chg_irr, input int eoi_mode, input logic [2:0] eoi_lvl);
    int         l;
    logic [2:0] lv;
    l = eligible(m_irr, m_isr);
    if (eoi_mode == 1)      m_isr = retire_highest(m_isr);
    else if (eoi_mode == 2) m_isr[eoi_lvl] = 1'b0;
    if (l >= 0) begin
      lv = 3'(l);
      exp_clear.push_back(8'h01 << lv);
      m_isr[lv] = 1'b1;
    end else begin
      lv = 3'd7;
    end
    cpu_bus.inta_n = 1'b0;
    eoi_i          = (eoi_mode != 0);
    eoi_specific_i = (eoi_mode == 2);
    eoi_level_i    = eoi_lvl;
    step();
    eoi_i = 1'b0;
    check("int_drop", {7'd0, cpu_bus.int_o}, 8'h00);
    check("freeze_set", {7'd0, freeze_o}, 8'h01);
    check("isr_ack1", isr_o, m_isr);
    if (chg_irr) begin
      irr   = 8'($urandom);
      m_irr = irr;
    end
    step();
    cpu_bus.inta_n = 1'b1;
    step();
    step();
    exp_data.push_back({vector_base, lv});
    cpu_bus.inta_n = 1'b0;
    step();
    step();
    check("oe_hold", {7'd0, cpu_bus.data_oe_o}, 8'h01);
    cpu_bus.inta_n = 1'b1;
    step();
    if (m_aeoi && l >= 0) m_isr[lv] = 1'b0;
    check("oe_drop", {7'd0, cpu_bus.data_oe_o}, 8'h00);
    check("freeze_drop", {7'd0, freeze_o}, 8'h00);
    check("isr_end", isr_o, m_isr);
    step();
    check("data_hold", cpu_bus.data_o, {vector_base, lv});
  endtask

  task automatic check_reset_outputs();
    check("rst_int", {7'd0, cpu_bus.int_o}, 8'h00);
    check("rst_freeze", {7'd0, freeze_o}, 8'h00);
    check("rst_oe", {7'd0, cpu_bus.data_oe_o}, 8'h00);
    check("rst_isr", isr_o, 8'h00);
    check("rst_clear", clear_irr_o, 8'h00);
    check("rst_data", cpu_bus.data_o, 8'h00);
  endtask

  initial begin
    rst_n          = 1'b0;
    irr            = '0;
    vector_base    = '0;
    eoi_i          = 1'b0;
    eoi_specific_i = 1'b0;
    eoi_level_i    = '0;
    aeoi_i         = 1'b0;
    cpu_bus.inta_n = 1'b1;
    m_irr          = '0;
    m_isr          = '0;
    m_aeoi         = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();
    step();

    // First acknowledge: irr=24 -> level 2, vector 8A
    vector_base = 5'h11;
    set_irr(8'h24);
    do_ack(1'b0, 0, 3'd0);
    check("first_isr", isr_o, 8'h04);

    // Nesting: level 3 blocked behind in-service 2, level 1 preempts
    set_irr(8'h08);
    set_irr(8'h02);
    do_ack(1'b0, 0, 3'd0);

    // EOI sequence, including EOI with an empty ISR
    do_eoi(0, 3'd0);
    do_eoi(1, 3'd2);
    do_eoi(0, 3'd0);

    // Spurious acknowledge
    set_irr(8'h00);
    do_ack(1'b0, 0, 3'd0);

    // EOI on the same edge as an acknowledge: lowest pre-update bit retired, new bit set
    set_irr(8'h08);
    do_ack(1'b0, 0, 3'd0);
    set_irr(8'h02);
    do_ack(1'b0, 1, 3'd0);
    // Specific EOI aimed at the level being set loses to the set
    do_eoi(1, 3'd1);
    set_irr(8'h01);
    do_ack(1'b1, 2, 3'd0);
    do_eoi(0, 3'd0);

    // Reset during WAIT2, then a clean repeat of the first acknowledge
    set_irr(8'h24);
    exp_clear.push_back(8'h04);
    cpu_bus.inta_n = 1'b0;
    step();
    step();
    cpu_bus.inta_n = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    m_isr = '0;
    step();
    rst_n = 1'b1;
    step();
    step();
    set_irr(8'h24);
    do_ack(1'b0, 0, 3'd0);
    check("after_reset_isr", isr_o, 8'h04);
    do_eoi(0, 3'd0);

`ifdef PIC_AEOI_EN
    aeoi_i = 1'b1;
    m_aeoi = 1'b1;
    set_irr(8'h01);
    do_ack(1'b0, 0, 3'd0);
    check("aeoi_isr", isr_o, 8'h00);
    aeoi_i = 1'b0;
    m_aeoi = 1'b0;
`endif

    // Randomized traffic against the reference model
    for (int it = 0; it < 80; it++) begin
      int unsigned op;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          vector_base = 5'($urandom);
          set_irr(8'($urandom & $urandom));
        end
        1: do_ack(1'($urandom), int'($urandom_range(0, 2)), 3'($urandom));
        2: do_eoi(int'($urandom_range(0, 1)), 3'($urandom));
        default: begin
          step();
          check("idle_isr", isr_o, m_isr);
        end
      endcase
    end

    step();
    step();
    check("clear_queue_empty", 8'(exp_clear.size()), 8'h00);
    check("data_queue_empty", 8'(exp_data.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
